// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: FSM encoding, slave-select helper and default widths for apb_rr_master_arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 33;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;
  function automatic int slv_sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction
endpackage

// File: rtl/apb_rr_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  int w_idx;
  logic w_found;
  // scan clients starting just after the previous owner, wrapping around
  always_comb begin
    w_idx = 0;
    w_found = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = (int'(last_grant) + i) % N;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        grant_idx = IW'(w_idx);
      end
    end
    grant_onehot = w_found ? (N'(1) << grant_idx) : '0;
    any = |req;
  end
endmodule

// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: round-robin multi-client APB master for two slaves; optional APB_TIMEOUT_EN
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      PSEL1,
  output logic                      PSEL2,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SEL = slv_sel_bit(ADDR_W);
  state_t r_state, w_next;
  logic [IW-1:0] r_last, w_gidx;
  logic [NUM_REQ-1:0] w_gnt, r_rsp_valid;
  logic w_any, w_accept, w_done, w_tmo;
  logic [ADDR_W-1:0] r_addr;
  logic r_write, r_err;
  logic [DATA_W-1:0] r_wdata, r_rdata;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid), .last_grant(r_last),
    .grant_onehot(w_gnt), .grant_idx(w_gidx), .any(w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;
  assign w_done   = (r_state == ACCESS) && (PREADY || w_tmo);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  // count ACCESS cycles; restarts every SETUP
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) r_cnt <= '0;
    else if (r_state == SETUP) r_cnt <= '0;
    else if (r_state == ACCESS) r_cnt <= r_cnt + CW'(1);
  assign w_tmo = (r_state == ACCESS) && !PREADY && (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // state register; async reset aborts any transfer in flight
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) r_state <= IDLE;
    else r_state <= w_next;

  // IDLE -> SETUP on grant, SETUP lasts one cycle, ACCESS until ready or timeout
  always_comb
    w_next = (r_state == IDLE)   ? (w_any ? SETUP : IDLE) :
             (r_state == SETUP)  ? ACCESS :
             (r_state == ACCESS) ? (w_done ? IDLE : ACCESS) : IDLE;

  // bus strobes and client accept derived from state
  always_comb begin
    busy = r_state != IDLE;
    PSEL1 = busy && !r_addr[SEL];
    PSEL2 = busy && r_addr[SEL];
    PENABLE = r_state == ACCESS;
    req_ready = (w_accept && !PRESET) ? w_gnt : '0;
  end

  // latch the granted client's command; owner doubles as round-robin pointer
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      r_addr <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_last <= IW'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_addr <= req_addr[w_gidx*ADDR_W +: ADDR_W];
      r_write <= req_write[w_gidx];
      r_wdata <= req_wdata[w_gidx*DATA_W +: DATA_W];
      r_last <= w_gidx;
    end

  // one-cycle completion pulse with captured data and error
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      r_rsp_valid <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_rsp_valid <= w_done ? (NUM_REQ'(1) << r_last) : '0;
      if (w_done) begin
        r_rdata <= (r_write || w_tmo) ? '0 : PRDATA;
        r_err <= w_tmo || PSLVERR;
      end
    end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign PADDR     = r_addr;
  assign PWRITE    = r_write;
  assign PWDATA    = r_wdata;
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb_apb_rr_master_arbiter: randomized and directed checks against a round-robin transfer model
module tb_apb_rr_master_arbiter;
  localparam int N = 4, AW = 33, DW = 32;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA = '0;
  logic [AW-1:0] PADDR;
  logic rsp_err, busy, PSEL1, PSEL2, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
  int n_cmp = 0, n_mis = 0, ptr = N - 1;
  logic [N-1:0] a_ready, s_ready, r_valid, r_ready;
  logic s_psel1, s_psel2, s_pen, s_pwrite, s_busy, r_err, r_busy, acc_ok;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata, r_rdata;
  int n_acc;

  apb_rr_master_arbiter dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic step;
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_client(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[c] = w;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  // drive one transfer: accept, setup, waits+1 access cycles, response cycle; records observations
  task automatic run_xfer(input logic [N-1:0] v, input int waits, input logic [DW-1:0] rd, input logic se);
    step;
    req_valid = v;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    a_ready = req_ready;
    step;
    req_valid = v & ~a_ready;
    for (int i = 0; i < N; i++) set_client(i, 1'($urandom), {1'($urandom), 32'($urandom)}, $urandom);
    @(negedge PCLK);
    {s_psel1, s_psel2, s_pen, s_pwrite, s_paddr, s_pwdata, s_busy, s_ready} =
      {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, busy, req_ready};
    acc_ok = 1'b1;
    n_acc = 0;
    for (int k = 0; k <= waits; k++) begin
      step;
      PREADY = (k == waits);
      PRDATA = (k == waits) ? rd : $urandom;
      PSLVERR = (k == waits) ? se : 1'($urandom);
      @(negedge PCLK);
      n_acc++;
      acc_ok &= (PSEL1 == s_psel1) && (PSEL2 == s_psel2) && PENABLE && (PADDR == s_paddr) &&
                (PWRITE == s_pwrite) && (PWDATA == s_pwdata) && (req_ready == '0) && (rsp_valid == '0);
    end
    step;
    req_valid = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    {r_valid, r_rdata, r_err, r_busy, r_ready} = {rsp_valid, rsp_rdata, rsp_err, busy, req_ready};
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got ready=%b rsp=%b busy=%b psel=%b%b pen=%b paddr=%h", req_ready, rsp_valid, busy, PSEL1, PSEL2, PENABLE, PADDR);
    end
    PRESET = 1'b0;
    req_valid = '0;
    ptr = N - 1;
  endtask

  task automatic test_single_read;
    set_client(0, 1'b0, 33'h0_0000_0010, 32'h0);
    run_xfer(4'b0001, 0, 32'hA5A5_0001, 1'b0);
    n_cmp++;
    if (a_ready !== 4'b0001) begin n_mis++; $display("FAIL read_ready: got %b want 0001", a_ready); end
    n_cmp++;
    if ({s_psel1, s_psel2, s_pen, s_paddr, s_busy} !== {3'b100, 33'h0_0000_0010, 1'b1}) begin
      n_mis++; $display("FAIL read_setup: got psel=%b%b pen=%b paddr=%h", s_psel1, s_psel2, s_pen, s_paddr);
    end
    n_cmp++;
    if ({r_valid, r_rdata, r_err, r_busy} !== {4'b0001, 32'hA5A5_0001, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL read_rsp: got v=%b d=%h e=%b want 0001 a5a50001 0", r_valid, r_rdata, r_err);
    end
    ptr = 0;
  endtask

  task automatic test_write;
    set_client(2, 1'b1, 33'h1_0000_0004, 32'hDEAD_BEEF);
    run_xfer(4'b0100, 0, 32'h1234_5678, 1'b0);
    n_cmp++;
    if ({s_psel1, s_psel2, s_pen, s_pwrite, s_pwdata} !== {4'b0101, 32'hDEAD_BEEF} || !acc_ok) begin
      n_mis++; $display("FAIL write_bus: got psel=%b%b pwrite=%b pwdata=%h stable=%b", s_psel1, s_psel2, s_pwrite, s_pwdata, acc_ok);
    end
    n_cmp++;
    if ({r_valid, r_rdata} !== {4'b0100, 32'h0}) begin
      n_mis++; $display("FAIL write_rsp: got v=%b d=%h want 0100 0", r_valid, r_rdata);
    end
    ptr = 2;
  endtask

  task automatic test_wait_states;
    set_client(3, 1'b0, 33'h1_0000_0100, 32'h0);
    run_xfer(4'b1000, 3, 32'h0BAD_F00D, 1'b0);
    n_cmp++;
    if (n_acc !== 4 || !acc_ok || !s_psel2) begin
      n_mis++; $display("FAIL wait_access: got cycles=%0d stable=%b psel2=%b want 4 1 1", n_acc, acc_ok, s_psel2);
    end
    n_cmp++;
    if ({r_valid, r_rdata} !== {4'b1000, 32'h0BAD_F00D}) begin
      n_mis++; $display("FAIL wait_rsp: got v=%b d=%h", r_valid, r_rdata);
    end
    ptr = 3;
  endtask

  task automatic test_slverr;
    set_client(1, 1'b0, 33'h0_0000_0020, 32'h0);
    run_xfer(4'b0010, 1, 32'hCAFE_0002, 1'b1);
    n_cmp++;
    if ({r_valid, r_err, r_rdata} !== {4'b0010, 1'b1, 32'hCAFE_0002}) begin
      n_mis++; $display("FAIL slverr_rsp: got v=%b e=%b d=%h want 0010 1 cafe0002", r_valid, r_err, r_rdata);
    end
    ptr = 1;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] er, ev;
    PRESET = 1'b1;
    step;
    PRESET = 1'b0;
    req_valid = '1;
    PREADY = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step;
      if (c == 15) req_valid = '0;
      @(negedge PCLK);
      er = (c % 3 == 0 && c < 15) ? 4'(1) << ((c / 3) % N) : '0;
      ev = (c % 3 == 0 && c > 0) ? 4'(1) << ((c / 3 - 1) % N) : '0;
      n_cmp++;
      if (req_ready !== er || rsp_valid !== ev || (PSEL1 && PSEL2)) begin
        n_mis++; $display("FAIL rr_cycle%0d: got ready=%b rsp=%b psel=%b%b want ready=%b rsp=%b", c, req_ready, rsp_valid, PSEL1, PSEL2, er, ev);
      end
    end
    PREADY = 1'b0;
    ptr = 0;
  endtask

  task automatic test_back_to_back;
    int g1, g2;
    g1 = rr_pick(4'b0011, ptr);
    g2 = rr_pick(4'b0011, g1);
    step;
    req_valid = 4'b0011;
    PREADY = 1'b1;
    @(negedge PCLK);
    n_cmp++;
    if (req_ready !== 4'(1) << g1) begin n_mis++; $display("FAIL b2b_first: got %b want client %0d", req_ready, g1); end
    step;
    req_valid = 4'b0011 & ~(4'(1) << g1);
    step;
    step;
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 4'(1) << g1 || req_ready !== 4'(1) << g2) begin
      n_mis++; $display("FAIL b2b_overlap: got rsp=%b ready=%b want clients %0d/%0d", rsp_valid, req_ready, g1, g2);
    end
    step;
    req_valid = '0;
    step;
    step;
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 4'(1) << g2) begin n_mis++; $display("FAIL b2b_second: got %b want client %0d", rsp_valid, g2); end
    PREADY = 1'b0;
    ptr = g2;
  endtask

  task automatic test_reset_abort;
    set_client(2, 1'b0, 33'h1_0000_0040, 32'h0);
    set_client(0, 1'b0, 33'h0_0000_0044, 32'h0);
    set_client(3, 1'b0, 33'h0_0000_0048, 32'h0);
    step;
    req_valid = 4'b0100;
    step;
    req_valid = '0;
    step;
    @(negedge PCLK);
    n_cmp++;
    if (!(PSEL2 && PENABLE)) begin n_mis++; $display("FAIL abort_pre: got psel2=%b pen=%b want 1 1", PSEL2, PENABLE); end
    #2 PRESET = 1'b1;
    #1;
    n_cmp++;
    if ({PSEL1, PSEL2, PENABLE, busy, rsp_valid, PADDR} !== '0) begin
      n_mis++; $display("FAIL abort_async: got psel=%b%b pen=%b busy=%b rsp=%b", PSEL1, PSEL2, PENABLE, busy, rsp_valid);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    ptr = N - 1;
    step;
    req_valid = 4'b1001;
    @(negedge PCLK);
    n_cmp++;
    if (req_ready !== 4'b0001 || rsp_valid !== '0) begin
      n_mis++; $display("FAIL abort_after: got ready=%b rsp=%b want 0001 0000", req_ready, rsp_valid);
    end
    step;
    req_valid = '0;
    step;
    PREADY = 1'b1;
    step;
    PREADY = 1'b0;
    @(negedge PCLK);
    n_cmp++;
    if (rsp_valid !== 4'b0001) begin n_mis++; $display("FAIL abort_resume: got %b want 0001", rsp_valid); end
    ptr = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    bit seen;
    set_client(1, 1'b0, 33'h1_0000_0080, 32'h0);
    step;
    req_valid = 4'b0010;
    step;
    req_valid = '0;
    cyc = 0;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step;
      PRDATA = $urandom;
      @(negedge PCLK);
      if (PENABLE) cyc++;
      if (rsp_valid != '0) seen = 1;
    end
    n_cmp++;
    if (!seen || cyc != 16 || rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      n_mis++; $display("FAIL timeout_rsp: got seen=%0d access=%0d v=%b e=%b d=%h want 1 16 0010 1 0", seen, cyc, rsp_valid, rsp_err, rsp_rdata);
    end
    ptr = 1;
  endtask
`endif

  task automatic test_random;
    logic [N-1:0] v, eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, rd;
    logic ew, se;
    int g, w;
    for (int it = 0; it < 40; it++) begin
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) set_client(i, 1'($urandom), {1'($urandom), 32'($urandom)}, $urandom);
      w = $urandom_range(0, 3);
      rd = $urandom;
      se = 1'($urandom);
      g = rr_pick(v, ptr);
      eg = 4'(1) << g;
      ea = req_addr[g*AW +: AW];
      ew = req_write[g];
      ed = req_wdata[g*DW +: DW];
      run_xfer(v, w, rd, se);
      n_cmp++;
      if (a_ready !== eg) begin n_mis++; $display("FAIL rand%0d_grant: got %b want %b", it, a_ready, eg); end
      n_cmp++;
      if ({s_psel1, s_psel2, s_pen, s_pwrite, s_paddr, s_pwdata, s_busy, s_ready} !== {~ea[AW-1], ea[AW-1], 1'b0, ew, ea, ed, 1'b1, 4'b0}) begin
        n_mis++; $display("FAIL rand%0d_setup: got psel=%b%b w=%b a=%h d=%h want w=%b a=%h d=%h", it, s_psel1, s_psel2, s_pwrite, s_paddr, s_pwdata, ew, ea, ed);
      end
      n_cmp++;
      if (!acc_ok || n_acc != w + 1) begin n_mis++; $display("FAIL rand%0d_access: got stable=%b cycles=%0d want 1 %0d", it, acc_ok, n_acc, w + 1); end
      n_cmp++;
      if ({r_valid, r_rdata, r_err, r_busy, r_ready} !== {eg, ew ? 32'h0 : rd, se, 1'b0, 4'b0}) begin
        n_mis++; $display("FAIL rand%0d_rsp: got v=%b d=%h e=%b want v=%b d=%h e=%b", it, r_valid, r_rdata, r_err, eg, ew ? 32'h0 : rd, se);
      end
      ptr = g;
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write;
    test_wait_states;
    test_slverr;
    test_back_to_back;
    test_random;
    test_reset_abort;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    test_round_robin;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
